ibuf_mp: RTL and testbench
==========================

// Module: ibuf_mp
// PURPOSE
//  Parametrised multi-port instruction buffer between fetch (IF) and decode (ID).
//  Accepts up to NPUSH fetched instructions per cycle and presents the oldest NPOP to decode.
//  Decode retires 0..NPOP of them per cycle, in order. Same role as the current 2-in/1-out buffer.
//  Generalised depth, push width and pop width; per-lane skip compaction; flush.
// PARAMETERS
//  DEPTH  8  entries; power of 2, >= max(4, NPUSH, NPOP)
//  NPUSH  2  fetch lanes per cycle, 1..4
//  NPOP   2  decode lanes per cycle, 1..4
//  W      `VA_SIZE+33  entry width {pr_taken, pc[`VA_BITS], opcode[31:0]}; derived, do not override
// PORTS
//  clk            in   1             clock, all state on posedge
//  reset_n        in   1             asynchronous, active-low reset
//  clear          in   1             synchronous flush (branch mispredict / redirect)
//  can_accept     out  NPUSH         bit k=1 <=> free entries >= k+1
//  push_vld       in   NPUSH         per-lane push strobe; any pattern legal
//  push_data      in   NPUSH*W       lane k at [k*W +: W]
//  pop_cnt        in   $clog2(NPOP+1)  instructions consumed by ID this cycle
//  out_vld        out  NPOP          thermometer; bit j=1 <=> entry rd_ptr+j valid
//  out_data       out  NPOP*W        lane j = entry at rd_ptr+j
//  occupancy      out  $clog2(DEPTH)+1  valid entries (registered state)
//  err_sticky     out  1             protocol-violation flag (see CONFIGURATION)
// BEHAVIOUR
//  - State: wr_ptr, rd_ptr, each $clog2(DEPTH)+1 bits with wrap bit; storage DEPTH x W.
//  - occupancy = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1). Full when it equals DEPTH.
//    Empty when it equals 0.
//  - Reset (reset_n=0, async): both pointers 0; storage 0; err_sticky 0.
//    Outputs during and after reset: out_vld=0, out_data=0, occupancy=0, can_accept=all 1s.
//  - Push compaction: set lanes go to consecutive entries from wr_ptr in ascending lane order.
//    Unset lanes are skipped. Example: push_vld=4'b1010 writes lane1 at wr_ptr and lane3 at wr_ptr+1.
//  - wr_ptr advances by the number of accepted lanes: popcount(push_vld), clamped.
//  - Push space uses start-of-cycle occupancy only. A same-cycle pop does not free space for a push.
//  - Overflow: lanes beyond the free-entry count are dropped, lowest-index lanes kept first.
//    This is a violation; IF must honour can_accept.
//  - Pop: rd_ptr advances by min(pop_cnt, occupancy). pop_cnt > occupancy or > NPOP is a violation.
//  - Outputs are combinational from registered state: no push-to-out bypass.
//    Push-to-out latency is 1 cycle; an entry written at edge t is visible after edge t.
//  - out_vld[j] = (occupancy > j) & ~clear. out_data lane j reads entry (rd_ptr+j) mod DEPTH.
//    Data on lanes with out_vld=0 is don't-care.
//  - Wrap-around: index = ptr[$clog2(DEPTH)-1:0]. Multi-lane writes and reads wrap mid-group.
//  - clear=1: at the next edge both pointers go to 0 and the cycle's push and pop are ignored.
//    out_vld is forced to 0 in the same cycle. can_accept and occupancy still reflect
//    pre-clear state. err_sticky is unaffected.
//  - Simultaneous push and pop at full: the pop is honoured, the push is dropped.
//    Simultaneous push and pop at empty: the push is honoured, the pop is a violation.
//  - No FSM beyond the pointer pair. All arithmetic is modular on pointer width.
// CONFIGURATION
//  IBUF_MP_ERR_EN
//   Defined: err_sticky sets on any overflow-push or over-pop. It clears only on reset_n.
//   An SVA assert fires on the violation cycle.
//   Undefined: err_sticky is tied 0, no assertions. Clamping behaviour is identical.
// TESTING
//  1 Reset: reset_n low mid-stream with occupancy=5 -> out_vld=0, occupancy=0, can_accept=2'b11
//    immediately (async).
//  2 Compaction: DEPTH=8, NPUSH=4, push_vld=4'b1010, lane1 pc=0x100, lane3 pc=0x108 ->
//    next cycle out_vld=2'b11, lane0 pc=0x100, lane1 pc=0x108.
//  3 Wrap: rd_ptr=wr_ptr=6, push 2 then 2 more -> entries at indices 6,7,0,1;
//    pop 2 twice returns them in order, wrap bit toggles.
//  4 Full/space: occupancy=7, DEPTH=8 -> can_accept=2'b01.
//    push 2 + pop 1 same cycle -> lane0 kept, lane1 dropped, occupancy=7; err_sticky=1 (ERR_EN).
//  5 Clear: occupancy=4, clear=1 with push_vld=2'b11 and pop_cnt=1 -> out_vld=0 that cycle;
//    next cycle occupancy=0, pointers 0.
//  6 Over-pop: occupancy=1, pop_cnt=2 -> occupancy=0, rd_ptr+1, err_sticky=1 only with IBUF_MP_ERR_EN.

Source files
------------

// File: rtl/ibuf_mp.sv
// rtl/ibuf_mp.sv - multi-port IF/ID instruction buffer with optional IBUF_MP_ERR_EN violation tracking
`ifndef VA_SIZE
`define VA_SIZE 32
`endif

module ibuf_mp #(
    parameter int DEPTH = 8,
    parameter int NPUSH = 2,
    parameter int NPOP  = 2,
    localparam int W    = `VA_SIZE + 33,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1,
    localparam int CW   = $clog2(NPOP + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    output logic [NPUSH-1:0]   can_accept,
    input  logic [NPUSH-1:0]   push_vld,
    input  logic [NPUSH*W-1:0] push_data,
    input  logic [CW-1:0]      pop_cnt,
    output logic [NPOP-1:0]    out_vld,
    output logic [NPOP*W-1:0]  out_data,
    output logic [PW-1:0]      occupancy,
    output logic               err_sticky
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] free_cnt, push_num, push_acc, pop_acc;
    logic [PW-1:0] slot [NPUSH];

    // slot[k] is lane k's offset from wr_ptr after skipping unset lanes below it
    always_comb begin
        occupancy = wr_ptr - rd_ptr;
        free_cnt  = PW'(DEPTH) - occupancy;
        push_num  = '0;
        for (int k = 0; k < NPUSH; k++) begin
            slot[k]  = push_num;
            push_num = push_num + PW'(push_vld[k]);
        end
        push_acc = (push_num > free_cnt) ? free_cnt : push_num;
        pop_acc  = (PW'(pop_cnt) > occupancy) ? occupancy : PW'(pop_cnt);
    end

    always_comb begin
        for (int k = 0; k < NPUSH; k++) begin
            can_accept[k] = (free_cnt >= PW'(k + 1));
        end
        for (int j = 0; j < NPOP; j++) begin
            out_vld[j]          = (occupancy > PW'(j)) & ~clear;
            out_data[j*W +: W]  = mem[rd_ptr[AW-1:0] + AW'(j)];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            for (int k = 0; k < NPUSH; k++) begin
                if (push_vld[k] && (slot[k] < free_cnt)) begin
                    mem[wr_ptr[AW-1:0] + slot[k][AW-1:0]] <= push_data[k*W +: W];
                end
            end
            wr_ptr <= wr_ptr + push_acc;
            rd_ptr <= rd_ptr + pop_acc;
        end
    end

`ifdef IBUF_MP_ERR_EN
    logic viol;
    assign viol = ~clear & ((push_num > free_cnt) | (PW'(pop_cnt) > occupancy) |
                            (pop_cnt > CW'(NPOP)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
        end else if (viol) begin
            err_sticky <= 1'b1;
        end
    end

    a_no_violation: assert property (@(posedge clk) disable iff (!reset_n) !viol);
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_ibuf_mp.sv
// tb/tb_ibuf_mp.sv - self-checking bench for ibuf_mp against a queue-based reference model
`ifndef VA_SIZE
`define VA_SIZE 32
`endif

module tb_ibuf_mp;
    localparam int DEPTH = 8;
    localparam int NPUSH = 4;
    localparam int NPOP  = 2;
    localparam int W     = `VA_SIZE + 33;
    localparam int PW    = $clog2(DEPTH) + 1;
    localparam int CW    = $clog2(NPOP + 1);
`ifdef IBUF_MP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               clear;
    logic [NPUSH-1:0]   can_accept;
    logic [NPUSH-1:0]   push_vld;
    logic [NPUSH*W-1:0] push_data;
    logic [CW-1:0]      pop_cnt;
    logic [NPOP-1:0]    out_vld;
    logic [NPOP*W-1:0]  out_data;
    logic [PW-1:0]      occupancy;
    logic               err_sticky;

    ibuf_mp #(.DEPTH(DEPTH), .NPUSH(NPUSH), .NPOP(NPOP)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .can_accept (can_accept),
        .push_vld   (push_vld),
        .push_data  (push_data),
        .pop_cnt    (pop_cnt),
        .out_vld    (out_vld),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mq [$];
    logic         m_err;
    int           n_pass  = 0;
    int           n_total = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] mk(input logic [31:0] pc, input logic [31:0] op);
        logic [W-1:0] e;
        e = '0;
        e[32 +: 32] = pc;
        e[31:0]     = op;
        return e;
    endfunction

    function automatic logic [NPUSH*W-1:0] rand_data();
        logic [NPUSH*W-1:0] d;
        logic [95:0]        r;
        for (int k = 0; k < NPUSH; k++) begin
            r = {$urandom, $urandom, $urandom};
            d[k*W +: W] = r[W-1:0];
        end
        return d;
    endfunction

    task automatic check_outputs();
        int sz;
        logic [NPUSH-1:0] ca;
        logic [NPOP-1:0]  ov;
        sz = mq.size();
        for (int k = 0; k < NPUSH; k++) ca[k] = ((DEPTH - sz) >= (k + 1));
        for (int j = 0; j < NPOP; j++) ov[j] = (sz > j) && !clear;
        chk("occupancy", 128'(occupancy), 128'(sz));
        chk("can_accept", 128'(can_accept), 128'(ca));
        chk("out_vld", 128'(out_vld), 128'(ov));
        for (int j = 0; j < NPOP; j++) begin
            if (ov[j]) chk("out_data", 128'(out_data[j*W +: W]), 128'(mq[j]));
        end
        chk("err_sticky", 128'(err_sticky), 128'(ERR_EN & m_err));
    endtask

    // Reference: pops come off the front, pushes land at the back limited by start-of-cycle space
    task automatic model_step(input logic [NPUSH-1:0] v, input int pc, input logic clr,
                              input logic [NPUSH*W-1:0] d);
        int sz, free_n, n, pops;
        sz     = mq.size();
        free_n = DEPTH - sz;
        n      = 0;
        if (clr) begin
            mq.delete();
        end else begin
            if (pc > sz || pc > NPOP || $countones(v) > free_n) m_err = 1'b1;
            pops = (pc < sz) ? pc : sz;
            repeat (pops) void'(mq.pop_front());
            for (int k = 0; k < NPUSH; k++) begin
                if (v[k]) begin
                    if (n < free_n) mq.push_back(d[k*W +: W]);
                    n++;
                end
            end
        end
    endtask

    task automatic cycle(input logic [NPUSH-1:0] v, input int pc, input logic clr,
                         input logic [NPUSH*W-1:0] d);
        push_vld  = v;
        pop_cnt   = CW'(pc);
        clear     = clr;
        push_data = d;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step(v, pc, clr, d);
        #1;
        push_vld = '0;
        pop_cnt  = '0;
        clear    = 1'b0;
    endtask

    initial begin
        logic [NPUSH*W-1:0] d;
        logic [NPUSH-1:0]   v;
        int                 sz, free_n, pc, mx;

        reset_n = 1'b0; clear = 1'b0; push_vld = '0; pop_cnt = '0; push_data = '0;
        m_err = 1'b0;
        #1;
        check_outputs();
        chk("reset_out_data", 128'(out_data), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Compaction: lanes 1 and 3 land in consecutive entries
        d = rand_data();
        d[1*W +: W] = mk(32'h100, 32'h0000_0013);
        d[3*W +: W] = mk(32'h108, 32'h0000_0093);
        cycle(4'b1010, 0, 1'b0, d);
        #1;
        chk("cmp_vld", 128'(out_vld), 128'(2'b11));
        chk("cmp_pc0", 128'(out_data[32 +: 32]), 128'(32'h100));
        chk("cmp_pc1", 128'(out_data[W + 32 +: 32]), 128'(32'h108));
        cycle('0, 0, 1'b0, rand_data());

        // Wrap: bring both pointers to 6, then write 6,7,0,1 and drain
        cycle('0, 2, 1'b0, rand_data());
        cycle(4'b1111, 0, 1'b0, rand_data());
        cycle('0, 2, 1'b0, rand_data());
        cycle('0, 2, 1'b0, rand_data());
        cycle(4'b0011, 0, 1'b0, rand_data());
        cycle(4'b0011, 0, 1'b0, rand_data());
        cycle('0, 2, 1'b0, rand_data());
        cycle('0, 2, 1'b0, rand_data());

        // Near-full: push 2 + pop 1 at occupancy 7 keeps only lane 0
        cycle(4'b1111, 0, 1'b0, rand_data());
        cycle(4'b0111, 0, 1'b0, rand_data());
        #1;
        chk("full_can_accept", 128'(can_accept), 128'(4'b0001));
        cycle(4'b0011, 1, 1'b0, rand_data());
        #1;
        chk("full_occ", 128'(occupancy), 128'(7));
        chk("full_err", 128'(err_sticky), 128'(ERR_EN));

        // Clear at occupancy 4 with push and pop asserted
        cycle('0, 2, 1'b0, rand_data());
        cycle('0, 1, 1'b0, rand_data());
        cycle(4'b0011, 1, 1'b1, rand_data());
        #1;
        chk("clear_occ", 128'(occupancy), 128'(0));
        cycle('0, 0, 1'b0, rand_data());

        // Over-pop at occupancy 1
        cycle(4'b0001, 0, 1'b0, rand_data());
        cycle('0, 2, 1'b0, rand_data());
        cycle('0, 0, 1'b0, rand_data());

        // Asynchronous reset mid-cycle with occupancy 5
        cycle(4'b1111, 0, 1'b0, rand_data());
        cycle(4'b0001, 0, 1'b0, rand_data());
        chk("pre_reset_occ", 128'(occupancy), 128'(5));
        #2;
        reset_n = 1'b0;
        mq.delete();
        m_err = 1'b0;
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Random legal traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            sz     = mq.size();
            free_n = DEPTH - sz;
            v      = NPUSH'($urandom);
            while ($countones(v) > free_n) v = NPUSH'($urandom);
            mx = (sz < NPOP) ? sz : NPOP;
            pc = $urandom_range(0, mx);
            cycle(v, pc, ($urandom_range(0, 19) == 0), rand_data());
        end
        cycle('0, 0, 1'b0, rand_data());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
